servant_uart_tx: RTL and testbench



---
 rtl/servant_uart_tx.sv | 163 ++++++++++++++++
 tb/tb_servant_uart_tx.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/servant_uart_tx.sv
// rtl/servant_uart_tx.sv - Wishbone UART transmitter (8N1) with a small TX FIFO.
// Define SERVANT_UART_TX_PARITY_EN to append an even parity bit to every frame.
module servant_uart_tx #(
    parameter int DIV     = 278,
    parameter int FIFO_AW = 3
) (
    input  logic        wb_clk,
    input  logic        wb_rst,
    input  logic        i_wb_adr,
    input  logic [31:0] i_wb_dat,
    input  logic        i_wb_we,
    input  logic        i_wb_cyc,
    output logic [31:0] o_wb_rdt,
    output logic        o_wb_ack,
    output logic        o_uart_tx,
    output logic        o_busy
);
    localparam int          DEPTH    = 1 << FIFO_AW;
    localparam logic [15:0] BAUD_MAX = 16'(DIV - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

`ifdef SERVANT_UART_TX_PARITY_EN
    localparam state_t AFTER_DATA = S_PARITY;
    localparam logic   PAR_FLAG   = 1'b1;
`else
    localparam state_t AFTER_DATA = S_STOP;
    localparam logic   PAR_FLAG   = 1'b0;
`endif

    logic [7:0]         r_mem [DEPTH];
    logic [FIFO_AW-1:0] r_wr_ptr;
    logic [FIFO_AW-1:0] r_rd_ptr;
    logic [FIFO_AW:0]   r_count;
    logic               r_overrun;
    state_t             r_state;
    state_t             w_state_next;
    logic [15:0]        r_baud;
    logic [2:0]         r_bit;
    logic [7:0]         r_shift;
    logic               r_parity;
    logic               r_ack;
    logic               r_busy;

    logic        w_bus;
    logic        w_push_req;
    logic        w_full;
    logic        w_empty;
    logic        w_pop;
    logic        w_push;
    logic        w_bit_end;
    logic        w_tx;
    logic [31:0] w_status;
    logic        w_unused;

    // Every bus side effect is qualified by the ack cycle.
    assign w_bus      = i_wb_cyc & r_ack;
    assign w_push_req = w_bus & i_wb_we & !i_wb_adr;
    assign w_full     = r_count == (FIFO_AW + 1)'(DEPTH);
    assign w_empty    = r_count == '0;
    assign w_pop      = (r_state == S_IDLE) & !w_empty;
    assign w_push     = w_push_req & (!w_full | w_pop);
    assign w_bit_end  = r_baud == '0;
    assign w_unused   = ^i_wb_dat[31:8];

    always_comb begin
        w_status                 = '0;
        w_status[0]              = w_full;
        w_status[1]              = w_empty & (r_state == S_IDLE);
        w_status[2]              = r_overrun;
        w_status[3]              = PAR_FLAG;
        w_status[8 +: FIFO_AW+1] = r_count;
    end

    always_ff @(posedge wb_clk) begin
        if (wb_rst) r_ack <= 1'b0;
        else        r_ack <= i_wb_cyc & !r_ack;
    end

    assign o_wb_ack = r_ack;
    assign o_wb_rdt = (r_ack & i_wb_adr & !i_wb_we) ? w_status : '0;
    assign o_busy   = r_busy;

    always_ff @(posedge wb_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_wb_dat[7:0];
    end

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push & !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_push & w_pop) r_count <= r_count - 1'b1;
            if (w_push_req & w_full & !w_pop)
                r_overrun <= 1'b1;
            else if (w_bus & i_wb_we & i_wb_adr & i_wb_dat[2])
                r_overrun <= 1'b0;
        end
    end

    always_ff @(posedge wb_clk) begin
        if (wb_rst) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (!w_empty) w_state_next = S_START;
            S_START:  if (w_bit_end) w_state_next = S_DATA;
            S_DATA:   if (w_bit_end && r_bit == 3'd7) w_state_next = AFTER_DATA;
            S_PARITY: if (w_bit_end) w_state_next = S_STOP;
            S_STOP:   if (w_bit_end) w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_tx = 1'b1;
        case (r_state)
            S_START:  w_tx = 1'b0;
            S_DATA:   w_tx = r_shift[0];
            S_PARITY: w_tx = r_parity;
            default:  w_tx = 1'b1;
        endcase
    end

    assign o_uart_tx = w_tx;

    // Baud counter, bit index and shift register; reloaded at every bit boundary.
    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            r_baud   <= '0;
            r_bit    <= '0;
            r_shift  <= '0;
            r_parity <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_busy <= !w_empty | (r_state != S_IDLE);
            if (r_state == S_IDLE) begin
                r_baud <= BAUD_MAX;
                r_bit  <= '0;
                if (w_pop) begin
                    r_shift  <= r_mem[r_rd_ptr];
                    r_parity <= ^r_mem[r_rd_ptr];
                end
            end else if (w_bit_end) begin
                r_baud <= BAUD_MAX;
                if (r_state == S_DATA) begin
                    r_shift <= {1'b0, r_shift[7:1]};
                    r_bit   <= r_bit + 3'd1;
                end
            end else begin
                r_baud <= r_baud - 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_servant_uart_tx.sv
// tb/tb_servant_uart_tx.sv - directed self-checking bench for servant_uart_tx.
`timescale 1ns/1ps
module tb_servant_uart_tx;
    localparam int DIV     = 4;
    localparam int FIFO_AW = 2;
`ifdef SERVANT_UART_TX_PARITY_EN
    localparam int          NB  = 11;
    localparam logic [31:0] PAR = 32'h8;
`else
    localparam int          NB  = 10;
    localparam logic [31:0] PAR = 32'h0;
`endif
    localparam int F = NB * DIV;

    logic        wb_clk   = 1'b0;
    logic        wb_rst   = 1'b1;
    logic        i_wb_adr = 1'b0;
    logic [31:0] i_wb_dat = '0;
    logic        i_wb_we  = 1'b0;
    logic        i_wb_cyc = 1'b0;
    logic [31:0] o_wb_rdt;
    logic        o_wb_ack;
    logic        o_uart_tx;
    logic        o_busy;

    int          n_checks = 0;
    int          n_errors = 0;
    logic        tx_s   [256];
    logic        busy_s [256];
    logic [31:0] rd;
    logic [4:0]  ackv;
    int          cnt;

    servant_uart_tx #(.DIV(DIV), .FIFO_AW(FIFO_AW)) dut (
        .wb_clk    (wb_clk),
        .wb_rst    (wb_rst),
        .i_wb_adr  (i_wb_adr),
        .i_wb_dat  (i_wb_dat),
        .i_wb_we   (i_wb_we),
        .i_wb_cyc  (i_wb_cyc),
        .o_wb_rdt  (o_wb_rdt),
        .o_wb_ack  (o_wb_ack),
        .o_uart_tx (o_uart_tx),
        .o_busy    (o_busy)
    );

    always #5 wb_clk = ~wb_clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge wb_clk);
            #1;
        end
    endtask

    task automatic wb_write(input logic adr, input logic [31:0] dat);
        i_wb_adr = adr; i_wb_dat = dat; i_wb_we = 1'b1; i_wb_cyc = 1'b1;
        tick(1);
        check("wr_ack", 64'(o_wb_ack), 64'h1);
        tick(1);
        i_wb_cyc = 1'b0; i_wb_we = 1'b0;
    endtask

    task automatic wb_read(input logic adr, output logic [31:0] dat);
        i_wb_adr = adr; i_wb_we = 1'b0; i_wb_cyc = 1'b1;
        tick(1);
        check("rd_ack", 64'(o_wb_ack), 64'h1);
        dat = o_wb_rdt;
        tick(1);
        i_wb_cyc = 1'b0;
    endtask

    task automatic capture(input int n);
        for (int i = 0; i < n; i++) begin
            tick(1);
            tx_s[i]   = o_uart_tx;
            busy_s[i] = o_busy;
        end
    endtask

    function automatic logic [63:0] exp_frame(input logic [7:0] d);
        logic [10:0] bits;
        logic [63:0] v;
`ifdef SERVANT_UART_TX_PARITY_EN
        bits = {1'b1, ^d, d, 1'b0};
`else
        bits = {1'b0, 1'b1, d, 1'b0};
`endif
        v = '0;
        for (int k = 0; k < F; k++) v[k] = bits[k / DIV];
        return v;
    endfunction

    function automatic logic [63:0] seg(input int start);
        logic [63:0] v;
        v = '0;
        for (int k = 0; k < F; k++) v[k] = tx_s[start + k];
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] bytes [2];
        bytes[0] = 8'h55;
        bytes[1] = 8'h07;

        tick(3);
        check("rst_tx", 64'(o_uart_tx), 64'h1);
        check("rst_ack", 64'(o_wb_ack), 64'h0);
        check("rst_rdt", 64'(o_wb_rdt), 64'h0);
        check("rst_busy", 64'(o_busy), 64'h0);
        wb_rst = 1'b0;
        tick(1);
        wb_read(1'b1, rd);
        check("rst_status", 64'(rd), 64'(32'h2 | PAR));
        wb_read(1'b0, rd);
        check("data_read", 64'(rd), 64'h0);
        check("rdt_no_ack", 64'(o_wb_rdt), 64'h0);

        // single frames
        for (int b = 0; b < 2; b++) begin
            wb_write(1'b0, 32'(bytes[b]));
            check("pre_start_tx", 64'(o_uart_tx), 64'h1);
            capture(F + 1);
            check("frame", seg(0), exp_frame(bytes[b]));
            check("frame_end_tx", 64'(tx_s[F]), 64'h1);
            wb_read(1'b1, rd);
            check("post_frame_status", 64'(rd), 64'(32'h2 | PAR));
        end

        // back-to-back frames
        wb_write(1'b0, 32'hA3);
        fork
            wb_write(1'b0, 32'h0F);
            capture(2 * F + 3);
        join
        check("b2b_frame1", seg(0), exp_frame(8'hA3));
        check("b2b_gap", 64'(tx_s[F]), 64'h1);
        check("b2b_frame2", seg(F + 1), exp_frame(8'h0F));
        cnt = 0;
        for (int i = 0; i < 2 * F + 2; i++) cnt += int'(busy_s[i]);
        check("b2b_busy_high", 64'(cnt), 64'(2 * F + 2));
        check("b2b_busy_low", 64'(busy_s[2 * F + 2]), 64'h0);

        // cyc held for 5 cycles
        i_wb_adr = 1'b0; i_wb_dat = 32'h5A; i_wb_we = 1'b1; i_wb_cyc = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick(1);
            ackv[i] = o_wb_ack;
        end
        i_wb_cyc = 1'b0; i_wb_we = 1'b0;
        tick(1);
        check("held_ack_pattern", 64'(ackv), 64'h0A);
        wb_read(1'b1, rd);
        check("held_two_pushes", 64'(rd), 64'(32'h100 | PAR));
        cnt = 0;
        while (o_busy && cnt < 400) begin
            tick(1);
            cnt++;
        end
        check("drain_busy", 64'(o_busy), 64'h0);

        // overrun and full-with-pop
        for (int k = 0; k < 6; k++) wb_write(1'b0, 32'(8'h10 + k));
        wb_read(1'b1, rd);
        check("ovf_status", 64'(rd), 64'(32'h405 | PAR));
        wb_write(1'b1, 32'h3);
        wb_read(1'b1, rd);
        check("ovf_kept", 64'(rd), 64'(32'h405 | PAR));
        wb_write(1'b1, 32'h4);
        wb_read(1'b1, rd);
        check("ovf_cleared", 64'(rd), 64'(32'h401 | PAR));
        tick(F - 20);
        wb_write(1'b0, 32'h99);
        wb_read(1'b1, rd);
        check("full_push_with_pop", 64'(rd), 64'(32'h401 | PAR));

        // reset mid-frame
        wb_rst = 1'b1;
        tick(1);
        wb_rst = 1'b0;
        wb_write(1'b0, 32'h00);
        tick(18);
        check("bit3_low", 64'(o_uart_tx), 64'h0);
        wb_rst = 1'b1; i_wb_adr = 1'b0; i_wb_dat = 32'h77; i_wb_we = 1'b1; i_wb_cyc = 1'b1;
        tick(1);
        check("midrst_tx", 64'(o_uart_tx), 64'h1);
        check("midrst_ack", 64'(o_wb_ack), 64'h0);
        check("midrst_busy", 64'(o_busy), 64'h0);
        wb_rst = 1'b0; i_wb_cyc = 1'b0; i_wb_we = 1'b0;
        wb_read(1'b1, rd);
        check("midrst_status", 64'(rd), 64'(32'h2 | PAR));
        capture(60);
        cnt = 0;
        for (int i = 0; i < 60; i++) cnt += int'(!tx_s[i]);
        check("no_restart", 64'(cnt), 64'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
